riscv_div: RTL
==============

RISCV_DIV -- requirements
Module: riscv_div

Interface
REQ-001 Parameters: none; operand width fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 enable_i  input  1  request to start a divide when idle.
REQ-005 operator_i  input  2  operation: 2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU.
REQ-006 op_a_i  input  32  dividend.
REQ-007 op_b_i  input  32  divisor.
REQ-008 ex_ready_i  input  1  consumer accepts the result; completes the instruction.
REQ-009 result_o  output  32  quotient (DIV/DIVU) or remainder (REM/REMU).
REQ-010 multicycle_o  output  1  high while the unit stalls the pipeline.
REQ-011 ready_o  output  1  high when result_o is valid or the unit is idle with no request.

Function
REQ-012 The FSM SHALL have three states: IDLE, DIVIDE, FINISH.
REQ-013 In cycle T, with IDLE and enable_i=1, the unit SHALL capture op_a_i, op_b_i and operator_i; ready_o=0 and multicycle_o=1 in cycle T.
REQ-014 After capture, operands SHALL be held internally; changes on op_a_i/op_b_i/operator_i SHALL NOT affect the result.
REQ-015 Normal path: the state SHALL go IDLE -> DIVIDE for exactly 32 cycles (T+1..T+32) -> FINISH at T+33.
REQ-016 Fast path: if the captured divisor is 0, or the operation is signed with dividend 0x80000000 and divisor 0xFFFFFFFF, the state SHALL go IDLE -> FINISH (valid at T+1).
REQ-017 DIVIDE SHALL run radix-2 restoring division on unsigned magnitudes, one quotient bit per cycle, MSB first, with a 5-bit iteration counter that counts from 0 to 31 and never wraps past 31.
REQ-018 For DIV/REM, magnitudes SHALL be two's-complement absolute values; the quotient SHALL be negated when the operand signs differ; the remainder SHALL take the sign of the dividend.
REQ-019 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = dividend, for both signed and unsigned operations.
REQ-020 Signed overflow (0x80000000 / -1) SHALL give quotient 0x80000000 and remainder 0.
REQ-021 In DIVIDE: ready_o=0, multicycle_o=1.
REQ-022 In FINISH: ready_o=1, multicycle_o=0, result_o valid and stable.
REQ-023 FINISH SHALL be held while ex_ready_i=0; FINISH -> IDLE on ex_ready_i=1.
REQ-024 enable_i SHALL be ignored in DIVIDE and FINISH.
REQ-025 A new request SHALL be accepted in the cycle immediately after the IDLE return, so back-to-back operations cost no extra bubble beyond that cycle.
REQ-026 In IDLE without a request: result_o=0, ready_o=1, multicycle_o=0.
REQ-027 ex_ready_i in IDLE or DIVIDE SHALL have no effect.

Reset
REQ-028 On rst_n=0, at any time including mid-DIVIDE, the unit SHALL enter IDLE asynchronously and clear the counter, partial remainder, quotient and captured operands to 0.
REQ-029 Reset output values: result_o=0, ready_o=1, multicycle_o=0.
REQ-030 The first request SHALL be accepted in the first clock after rst_n deasserts.

Verification
REQ-031 DIVU 100/7 (op=01) -> FINISH at T+33, result_o=14; REMU same operands -> 2.
REQ-032 DIV 0xFFFFFFF9/2 (-7/2) -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-033 DIVU 5/0 -> 0xFFFFFFFF at T+1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; REM -> 0.
REQ-034 FINISH with ex_ready_i=0 for 3 cycles while op_a_i/op_b_i toggle -> result_o unchanged and ready_o=1 throughout; on ex_ready_i=1 the unit returns to IDLE, and enable_i next cycle starts a new op.
REQ-035 rst_n pulsed low at DIVIDE iteration 10 -> immediate IDLE, result_o=0, ready_o=1, multicycle_o=0; the next DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
REQ-036 Random signed/unsigned operand sweep checked against a reference model, including 0, 1, -1, 0x7FFFFFFF and 0x80000000 as dividends and divisors.

Source files
------------

// File: rtl/riscv_div.sv
// Iterative 32-bit integer divider for the RISC-V M extension (DIV/DIVU/REM/REMU).
// Radix-2 restoring division on magnitudes, one quotient bit per cycle, with a fast path for divide-by-zero and signed overflow.
module riscv_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic [1:0]  operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        ex_ready_i,
  output logic [31:0] result_o,
  output logic        multicycle_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;

  function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg(input logic [31:0] v, input logic do_neg);
    return do_neg ? (~v + 32'd1) : v;
  endfunction

  logic        sgn_i, fast_i;
  logic        sgn_q, dz_q, ovf_q;
  logic [31:0] b_mag;
  logic [32:0] rem_sh, diff;
  logic [31:0] q_res, r_res;

  assign sgn_i  = ~operator_i[0];
  assign fast_i = (op_b_i == 32'd0) ||
                  (sgn_i && (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF));

  assign sgn_q = ~op_q[0];
  assign dz_q  = (b_q == 32'd0);
  assign ovf_q = sgn_q && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign b_mag = mag(b_q, sgn_q);

  // The dividend magnitude sits in quo_q and shifts out MSB-first as quotient bits shift in.
  assign rem_sh = {rem_q, quo_q[31]};
  assign diff   = rem_sh - {1'b0, b_mag};

  assign q_res = dz_q  ? 32'hFFFF_FFFF :
                 ovf_q ? 32'h8000_0000 :
                 neg(quo_q, sgn_q && (a_q[31] ^ b_q[31]));
  assign r_res = dz_q  ? a_q :
                 ovf_q ? 32'd0 :
                 neg(rem_q, sgn_q && a_q[31]);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_o     = 32'd0;
    ready_o      = 1'b0;
    multicycle_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_o      = ~enable_i;
        multicycle_o = enable_i;
        if (enable_i) begin
          a_d     = op_a_i;
          b_d     = op_b_i;
          op_d    = operator_i;
          cnt_d   = 5'd0;
          rem_d   = 32'd0;
          quo_d   = mag(op_a_i, sgn_i);
          state_d = fast_i ? FINISH : DIVIDE;
        end
      end
      DIVIDE: begin
        multicycle_o = 1'b1;
        if (diff[32]) begin
          rem_d = rem_sh[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end else begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end
        if (cnt_q == 5'd31) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      FINISH: begin
        ready_o  = 1'b1;
        result_o = op_q[1] ? r_res : q_res;
        if (ex_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

endmodule
